axi_wr_master_split: RTL and testbench

Next-generation AXI write master for the DDR2 controller front end. It accepts one write request of arbitrary length (up to 2^LEN_WIDTH-1 beats) and splits it into sequential AXI INCR bursts. Each burst is at most MAX_BURST beats and never crosses a 2^COL_BITS-beat row boundary. It adds upstream data-valid throttling, full AXI sideband outputs and write-response error reporting.

---
 rtl/axi_wr_master_split_if.sv | 32 +++
 rtl/axi_wr_master_split.sv | 128 ++++++++++++
 tb/tb_axi_wr_master_split.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_master_split_if.sv
// AXI write-channel bundle (AW, W, B) between the split write master and the memory side.
interface axi_wr_master_split_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      wvalid;
    logic                      wready;
    logic                      wlast;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic [1:0]                bresp;
    logic                      bready;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wlast, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wlast, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_wr_master_split.sv
// Splits one arbitrary-length write request into sequential AXI INCR bursts,
// each capped at MAX_BURST beats and never crossing a 2^COL_BITS-beat row.
module axi_wr_master_split #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int COL_BITS   = 10,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init_end,
    input  logic                  wr_trig,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_data_valid,
    output logic                  wr_data_en,
    output logic                  wr_ready,
    output logic                  wr_done,
    output logic                  wr_err,
    axi_wr_master_split_if.master axi
);
    // Wide enough to hold remain, the row room (up to 2^COL_BITS) and MAX_BURST exactly.
    localparam int CW0 = (LEN_WIDTH > COL_BITS) ? LEN_WIDTH : COL_BITS;
    localparam int CW  = ((CW0 > 9) ? CW0 : 9) + 1;

    typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remain;
    logic [7:0]            beat_cnt;
    logic [8:0]            blen;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  done_q;
    logic                  err_q;
    logic [CW-1:0]         rem_x, row_x, max_x, blen_x;
    logic                  accept, aw_hs, wvalid, w_hs, b_hs;

    assign accept = (state == IDLE) && init_end && wr_trig;
    assign aw_hs  = (state == AW) && awvalid && axi.awready;
    assign wvalid = (state == W) && wr_data_valid;
    assign w_hs   = wvalid && axi.wready;
    assign b_hs   = (state == B) && axi.bvalid;

    assign rem_x = CW'(remain);
    assign row_x = (CW'(1) << COL_BITS) - CW'(cur_addr[COL_BITS-1:0]);
    assign max_x = CW'(MAX_BURST);

    always_comb begin
        blen_x = rem_x;
        if (max_x < blen_x) blen_x = max_x;
        if (row_x < blen_x) blen_x = row_x;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = (wr_len == '0) ? DONE : CALC;
            CALC:    state_nxt = AW;
            AW:      if (aw_hs) state_nxt = W;
            W:       if (w_hs && beat_cnt == 8'd0) state_nxt = B;
            B:       if (b_hs) state_nxt = (remain == '0) ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cur_addr <= '0;
            remain   <= '0;
            beat_cnt <= '0;
            blen     <= '0;
            awaddr   <= '0;
            awlen    <= '0;
            awvalid  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == DONE);
            if (accept) begin
                cur_addr <= wr_addr;
                remain   <= wr_len;
                err_q    <= 1'b0;
            end
            if (state == CALC) begin
                awaddr   <= cur_addr;
                awlen    <= 8'(blen_x - CW'(1));
                beat_cnt <= 8'(blen_x - CW'(1));
                blen     <= 9'(blen_x);
                awvalid  <= 1'b1;
            end
            if (aw_hs) awvalid <= 1'b0;
            if (w_hs) begin
                if (beat_cnt == 8'd0) begin
                    // address wraps modulo 2^ADDR_WIDTH by truncation
                    cur_addr <= cur_addr + ADDR_WIDTH'(blen);
                    remain   <= remain - LEN_WIDTH'(blen);
                end else begin
                    beat_cnt <= beat_cnt - 8'd1;
                end
            end
            if (b_hs && axi.bresp != 2'b00) err_q <= 1'b1;
        end
    end

    assign wr_ready   = (state == IDLE) && init_end;
    assign wr_done    = done_q;
    assign wr_err     = err_q;
    assign wr_data_en = w_hs;

    assign axi.awvalid = awvalid;
    assign axi.awaddr  = awaddr;
    assign axi.awlen   = awlen;
    assign axi.awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = wvalid;
    assign axi.wlast   = (state == W) && (beat_cnt == 8'd0);
    assign axi.wdata   = wr_data;
    assign axi.wstrb   = '1;
    assign axi.bready  = (state == B);
endmodule

// File: tb/tb_axi_wr_master_split.sv
// Directed bench: burst-list model plus per-cycle AW/W/B checker for axi_wr_master_split.
module tb_axi_wr_master_split;
    localparam int AW_W = 27;
    localparam int DW   = 16;
    localparam int COLB = 10;
    localparam int MAXB = 16;
    localparam int LW   = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            init_end;
    logic            wr_trig;
    logic [AW_W-1:0] wr_addr;
    logic [LW-1:0]   wr_len;
    logic [DW-1:0]   wr_data;
    logic            wr_data_valid;
    logic            wr_data_en, wr_ready, wr_done, wr_err;

    axi_wr_master_split_if #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) axi ();

    axi_wr_master_split #(
        .ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .COL_BITS(COLB), .MAX_BURST(MAXB), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rstn(rstn), .init_end(init_end), .wr_trig(wr_trig),
        .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .wr_data_en(wr_data_en), .wr_ready(wr_ready), .wr_done(wr_done), .wr_err(wr_err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model / scoreboard state
    logic [AW_W-1:0] exp_aw_addr[$];
    logic [7:0]      exp_aw_len[$];
    logic [DW-1:0]   exp_data[$];
    logic            exp_last[$];
    logic [AW_W-1:0] log_addr[$];
    logic [7:0]      log_len[$];
    int              nbursts, exp_err;

    // responder configuration and observed counts
    int        aw_delay = 0;
    bit        rnd_mode = 1'b0;
    int        err_burst = -1;
    logic [DW-1:0] dbase = '0;
    int        beats_taken = 0;
    int        b_cnt = 0;
    int        nlast = 0;
    bit        chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Burst list from the splitting rules: min(remaining, MAX_BURST, room left in row).
    task automatic build_model(input logic [AW_W-1:0] addr, input int len, input int errb);
        logic [AW_W-1:0] a;
        int rem, bl, room, idx;
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_data.delete(); exp_last.delete();
        a = addr; rem = len; idx = 0; exp_err = 0;
        while (rem > 0) begin
            room = (1 << COLB) - int'(a % (1 << COLB));
            bl = rem;
            if (bl > MAXB) bl = MAXB;
            if (bl > room) bl = room;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(8'(bl - 1));
            for (int i = 0; i < bl; i++) exp_last.push_back(i == bl - 1);
            if (idx == errb) exp_err = 1;
            a = a + AW_W'(bl);
            rem -= bl;
            idx++;
        end
        for (int i = 0; i < len; i++) exp_data.push_back(DW'(dbase + DW'(i)));
        nbursts = idx;
    endtask

    // responder: updates shortly after each rising edge
    int aw_wait = 0;
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        wr_data_valid = 1'b0; wr_data = '0;
        forever begin
            @(posedge clk); #2;
            if (!axi.awvalid) begin
                aw_wait = 0; axi.awready = 1'b0;
            end else begin
                axi.awready = (aw_wait >= aw_delay);
                aw_wait++;
            end
            axi.wready    = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data_valid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data       = DW'(dbase + DW'(beats_taken));
            axi.bvalid    = axi.bready;
            axi.bresp     = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        end
    end

    // per-cycle checker against the model queues
    logic            aw_pend = 1'b0;
    logic [AW_W-1:0] pend_addr;
    logic [7:0]      pend_len;
    initial forever begin
        @(negedge clk);
        if (!chk_en) begin
            aw_pend = 1'b0;
        end else begin
            chk("wr_data_en", wr_data_en, axi.wvalid && axi.wready);
            if (aw_pend && axi.awvalid) begin
                chk("awaddr_stable", axi.awaddr, pend_addr);
                chk("awlen_stable", axi.awlen, pend_len);
            end
            aw_pend = axi.awvalid && !axi.awready;
            pend_addr = axi.awaddr; pend_len = axi.awlen;
            if (axi.awvalid && axi.awready) begin
                log_addr.push_back(axi.awaddr); log_len.push_back(axi.awlen);
                if (exp_aw_addr.size() == 0) chk("aw_extra", 1, 0);
                else begin
                    chk("awaddr", axi.awaddr, exp_aw_addr.pop_front());
                    chk("awlen", axi.awlen, exp_aw_len.pop_front());
                end
                chk("awsize", axi.awsize, 3'd1);
                chk("awburst", axi.awburst, 2'b01);
            end
            if (axi.wvalid && axi.wready) begin
                beats_taken++;
                if (axi.wlast) nlast++;
                if (exp_data.size() == 0) chk("w_extra", 1, 0);
                else begin
                    chk("wdata", axi.wdata, exp_data.pop_front());
                    chk("wlast", axi.wlast, exp_last.pop_front());
                end
                chk("wstrb", axi.wstrb, 2'b11);
            end
            if (axi.bvalid && axi.bready) b_cnt++;
        end
    end

    task automatic start_req(input logic [AW_W-1:0] addr, input int len, input int dly,
                             input bit rnd, input int errb);
        int t;
        t = 0;
        while (!wr_ready && t < 50) begin @(negedge clk); t++; end
        chk("ready_before_req", wr_ready, 1'b1);
        aw_delay = dly; rnd_mode = rnd; err_burst = errb;
        dbase = DW'($urandom);
        beats_taken = 0; b_cnt = 0; nlast = 0;
        log_addr.delete(); log_len.delete();
        build_model(addr, len, errb);
        wr_addr = addr; wr_len = LW'(len); wr_trig = 1'b1;
    endtask

    task automatic run_req(input logic [AW_W-1:0] addr, input int len, input int dly,
                           input bit rnd, input int errb, output int aw_lat, output int done_lat);
        int cyc;
        start_req(addr, len, dly, rnd, errb);
        cyc = 0; aw_lat = -1; done_lat = -1;
        while (done_lat < 0 && cyc < 1000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == 1) wr_trig = 1'b0;
            if (aw_lat < 0 && axi.awvalid) aw_lat = cyc;
            if (wr_done) done_lat = cyc;
        end
        chk("done_seen", done_lat >= 0, 1'b1);
        chk("beats", beats_taken, len);
        chk("aw_left", exp_aw_addr.size(), 0);
        chk("b_before_done", b_cnt, nbursts);
        chk("wr_err", wr_err, exp_err);
        @(negedge clk);
        chk("done_pulse", wr_done, 1'b0);
    endtask

    int al, dl, t;
    bit seen;
    initial begin
        rstn = 1'b0; init_end = 1'b0; wr_trig = 1'b0; wr_addr = '0; wr_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_awaddr", axi.awaddr, 0);
        chk("rst_awlen", axi.awlen, 0);
        chk("rst_ready_noinit", wr_ready, 0);
        rstn = 1'b1; chk_en = 1'b1;

        // requests ignored while init_end is low
        build_model('0, 0, -1);
        wr_addr = 27'h40; wr_len = 16'd5; wr_trig = 1'b1; seen = 1'b0;
        repeat (6) begin @(negedge clk); if (axi.awvalid || wr_done) seen = 1'b1; end
        wr_trig = 1'b0;
        chk("no_init_ignored", seen, 0);
        init_end = 1'b1;
        @(negedge clk);
        chk("ready_init", wr_ready, 1);

        // aligned single burst
        run_req(27'h000, 8, 0, 0, -1, al, dl);
        chk("aw_latency", al, 2);
        chk("t1_nbursts", log_addr.size(), 1);
        chk("t1_awlen", log_len[0], 8'd7);
        chk("t1_nlast", nlast, 1);

        // split into MAX_BURST pieces
        run_req(27'h010, 40, 0, 0, -1, al, dl);
        chk("t2_nbursts", log_addr.size(), 3);
        chk("t2_a0", log_addr[0], 27'h010); chk("t2_l0", log_len[0], 8'd15);
        chk("t2_a1", log_addr[1], 27'h020); chk("t2_l1", log_len[1], 8'd15);
        chk("t2_a2", log_addr[2], 27'h030); chk("t2_l2", log_len[2], 8'd7);

        // row crossing
        run_req(27'h3FA, 12, 0, 0, -1, al, dl);
        chk("t3_nbursts", log_addr.size(), 2);
        chk("t3_a0", log_addr[0], 27'h3FA); chk("t3_l0", log_len[0], 8'd5);
        chk("t3_a1", log_addr[1], 27'h400); chk("t3_l1", log_len[1], 8'd5);

        // back-pressure on every channel
        run_req(27'h100, 20, 3, 1, -1, al, dl);
        chk("t4_nlast", nlast, 2);
        chk("t4_l0", log_len[0], 8'd15);
        chk("t4_l1", log_len[1], 8'd3);

        // SLVERR on first of two bursts, then empty request
        run_req(27'h200, 32, 0, 0, 0, al, dl);
        chk("t5_nbursts", log_addr.size(), 2);
        chk("t5_err", wr_err, 1);
        run_req(27'h300, 0, 0, 0, -1, al, dl);
        chk("t6_done_lat", dl, 2);
        chk("t6_no_aw", log_addr.size(), 0);
        chk("t6_err_clr", wr_err, 0);

        // reset in the middle of the W phase
        start_req(27'h500, 8, 0, 0, -1);
        @(negedge clk); wr_trig = 1'b0;
        t = 0;
        while (beats_taken < 2 && t < 100) begin @(negedge clk); t++; end
        chk("t7_reached_beat3", beats_taken, 2);
        @(posedge clk); #1 chk_en = 1'b0; rstn = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t7_awvalid", axi.awvalid, 0);
        chk("t7_wvalid", axi.wvalid, 0);
        chk("t7_wlast", axi.wlast, 0);
        chk("t7_bready", axi.bready, 0);
        chk("t7_idle", wr_ready, 1);
        rstn = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // normal request afterwards, wrapping the address space across a row
        run_req(27'h7FFFFFC, 8, 0, 0, -1, al, dl);
        chk("t8_nbursts", log_addr.size(), 2);
        chk("t8_a0", log_addr[0], 27'h7FFFFFC); chk("t8_l0", log_len[0], 8'd3);
        chk("t8_a1", log_addr[1], 27'h0000000); chk("t8_l1", log_len[1], 8'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
